// File: rtl/soc_simple_ocm_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip memory.
// Master 0 fetches instructions (read only); master 1 reads and writes data.
module soc_simple_ocm_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata,
   output logic [15:0]         stall_count
);

   localparam int BE_W = DATA_W / 8;

   logic req0;
   logic req1;
   logic gnt0;
   logic gnt1;
   logic rd_acc;
   logic stall_ev;

   // Set when m0 won the most recent grant; cleared state favours m0.
   logic last_grant_m0;
   logic rd_pend;
   logic rd_owner;

   assign req0 = m0_read;
   assign req1 = m1_read | m1_write;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (req0 && req1) begin
            gnt0 = !last_grant_m0;
            gnt1 = last_grant_m0;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   assign m0_waitrequest = !gnt0;
   assign m1_waitrequest = !gnt1;

   always_comb begin
      mem_chipselect = gnt0 | gnt1;
      mem_write      = gnt1 & m1_write;
      mem_address    = m0_address;
      mem_byteenable = {BE_W{1'b1}};
      mem_writedata  = m1_writedata;
      if (gnt1) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
      end
   end

   assign mem_clken = 1'b1;

   // Write wins when m1 illegally raises both read and write.
   assign rd_acc   = gnt0 | (gnt1 & m1_read & !m1_write);
   assign stall_ev = (req0 & !gnt0) | (req1 & !gnt1);

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_m0 <= 1'b0;
         rd_pend       <= 1'b0;
         rd_owner      <= 1'b0;
         stall_count   <= 16'h0000;
      end else begin
         if (gnt0 | gnt1)
            last_grant_m0 <= gnt0;
         rd_pend  <= rd_acc;
         rd_owner <= gnt1;
         if (stall_ev && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'h0001;
      end
   end

   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = !reset & rd_pend & !rd_owner;
   assign m1_readdatavalid = !reset & rd_pend & rd_owner;

endmodule

// File: tb/tb_soc_simple_ocm_arbiter.sv
// Directed bench for soc_simple_ocm_arbiter with a 1-cycle behavioural RAM.
// Inputs change on the falling edge; outputs are checked away from posedge.
module tb_soc_simple_ocm_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  m0_address;
   logic        m0_read;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m0_readdatavalid;
   logic [9:0]  m1_address;
   logic        m1_read;
   logic        m1_write;
   logic [3:0]  m1_byteenable;
   logic [31:0] m1_writedata;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        m1_readdatavalid;
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata;
   logic [15:0] stall_count;

   int total  = 0;
   int passed = 0;

   logic [31:0] ram [0:1023];

   always #5 clk = ~clk;

   soc_simple_ocm_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk(clk),
      .reset(reset),
      .m0_address(m0_address),
      .m0_read(m0_read),
      .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address),
      .m1_read(m1_read),
      .m1_write(m1_write),
      .m1_byteenable(m1_byteenable),
      .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address),
      .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect),
      .mem_write(mem_write),
      .mem_writedata(mem_writedata),
      .mem_clken(mem_clken),
      .mem_readdata(mem_readdata),
      .stall_count(stall_count)
   );

   initial begin
      for (int i = 0; i < 1024; i++)
         ram[i] = 32'hA500_0000 | i;
   end

   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b])
                  ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic idle();
      m0_read  = 1'b0;
      m1_read  = 1'b0;
      m1_write = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      m0_address    = '0;
      m1_address    = '0;
      m1_byteenable = 4'hF;
      m1_writedata  = '0;
      mem_readdata  = '0;
      m0_read       = 1'b1;
      m1_read       = 1'b0;
      m1_write      = 1'b1;

      // Requests held during reset must see no grant
      @(negedge clk);
      #1;
      chk("rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
      chk("rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
      chk("rst_cs", {31'd0, mem_chipselect}, 32'd0);
      chk("rst_wr", {31'd0, mem_write}, 32'd0);
      chk("rst_valids", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
      idle();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_stall", {16'd0, stall_count}, 32'd0);
      chk("idle_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
      chk("idle_cs", {31'd0, mem_chipselect}, 32'd0);
      chk("clken", {31'd0, mem_clken}, 32'd1);

      // Single m0 read
      @(negedge clk);
      m0_read    = 1'b1;
      m0_address = 10'h010;
      #1;
      chk("m0_single_wait", {31'd0, m0_waitrequest}, 32'd0);
      chk("m0_single_addr", {22'd0, mem_address}, 32'h010);
      chk("m0_single_be", {28'd0, mem_byteenable}, 32'hF);
      @(negedge clk);
      idle();
      #1;
      chk("m0_single_valid", {31'd0, m0_readdatavalid}, 32'd1);
      chk("m0_single_data", m0_readdata, 32'hA500_0010);
      chk("m0_single_m1v", {31'd0, m1_readdatavalid}, 32'd0);
      @(negedge clk);
      #1;
      chk("m0_single_done", {31'd0, m0_readdatavalid}, 32'd0);

      // Four cycles of conflict right after reset
      do_reset();
      m0_read    = 1'b1;
      m0_address = 10'h020;
      m1_read    = 1'b1;
      m1_address = 10'h030;
      #1;
      chk("rr0_m0", {31'd0, m0_waitrequest}, 32'd0);
      chk("rr0_m1", {31'd0, m1_waitrequest}, 32'd1);
      @(negedge clk);
      #1;
      chk("rr1_m0", {31'd0, m0_waitrequest}, 32'd1);
      chk("rr1_m1", {31'd0, m1_waitrequest}, 32'd0);
      chk("rr1_v0", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'b10);
      chk("rr1_d0", m0_readdata, 32'hA500_0020);
      @(negedge clk);
      #1;
      chk("rr2_m0", {31'd0, m0_waitrequest}, 32'd0);
      chk("rr2_v1", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'b01);
      chk("rr2_d1", m1_readdata, 32'hA500_0030);
      @(negedge clk);
      #1;
      chk("rr3_m1", {31'd0, m1_waitrequest}, 32'd0);
      chk("rr3_v0", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'b10);
      @(negedge clk);
      idle();
      #1;
      chk("rr4_v1", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'b01);
      chk("rr_stall", {16'd0, stall_count}, 32'd4);

      // Partial write then read-back of the top word
      @(negedge clk);
      m1_write      = 1'b1;
      m1_address    = 10'h3FF;
      m1_writedata  = 32'hDEAD_BEEF;
      m1_byteenable = 4'b0011;
      #1;
      chk("wr_wait", {31'd0, m1_waitrequest}, 32'd0);
      chk("wr_memwr", {31'd0, mem_write}, 32'd1);
      chk("wr_be", {28'd0, mem_byteenable}, 32'h3);
      @(negedge clk);
      m1_write = 1'b0;
      m1_read  = 1'b1;
      #1;
      chk("wr_novalid", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
      chk("rb_memwr", {31'd0, mem_write}, 32'd0);
      @(negedge clk);
      idle();
      #1;
      chk("rb_valid", {31'd0, m1_readdatavalid}, 32'd1);
      chk("rb_data", m1_readdata, 32'hA500_BEEF);

      // Write accepted right after an m0 read
      @(negedge clk);
      m0_read    = 1'b1;
      m0_address = 10'h005;
      @(negedge clk);
      m0_read       = 1'b0;
      m1_write      = 1'b1;
      m1_address    = 10'h006;
      m1_byteenable = 4'hF;
      m1_writedata  = 32'h1234_5678;
      #1;
      chk("rw_wait", {31'd0, m1_waitrequest}, 32'd0);
      chk("rw_v", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'b10);
      chk("rw_d", m0_readdata, 32'hA500_0005);
      @(negedge clk);
      idle();
      #1;
      chk("rw_nov", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);

      // Read in flight is dropped by reset
      @(negedge clk);
      m1_read    = 1'b1;
      m1_address = 10'h007;
      #1;
      chk("drop_acc", {31'd0, m1_waitrequest}, 32'd0);
      @(negedge clk);
      idle();
      reset = 1'b1;
      #1;
      chk("drop_v_rst", {31'd0, m1_readdatavalid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("drop_v_after", {31'd0, m1_readdatavalid}, 32'd0);
      chk("drop_stall", {16'd0, stall_count}, 32'd0);

      // Last-grant holds across an idle cycle
      m0_read    = 1'b1;
      m0_address = 10'h001;
      @(negedge clk);
      idle();
      @(negedge clk);
      m0_read = 1'b1;
      m1_read = 1'b1;
      #1;
      chk("lg_m1_wins", {30'd0, m0_waitrequest, m1_waitrequest}, 32'b10);
      @(negedge clk);
      idle();

      // Back-to-back m0 fetches
      do_reset();
      for (int i = 0; i < 5; i++) begin
         m0_read    = 1'b1;
         m0_address = 10'h100 + 10'(i);
         #1;
         chk("burst_wait", {31'd0, m0_waitrequest}, 32'd0);
         if (i > 0) begin
            chk("burst_valid", {31'd0, m0_readdatavalid}, 32'd1);
            chk("burst_data", m0_readdata, 32'hA500_0100 + 32'(i - 1));
         end
         @(negedge clk);
      end
      idle();
      #1;
      chk("burst_last", m0_readdata, 32'hA500_0104);

      // Saturation of the stall counter
      do_reset();
      m0_read = 1'b1;
      m1_read = 1'b1;
      repeat (65540) @(posedge clk);
      @(negedge clk);
      #1;
      chk("sat_stall", {16'd0, stall_count}, 32'h0000_FFFF);
      @(negedge clk);
      #1;
      chk("sat_hold", {16'd0, stall_count}, 32'h0000_FFFF);
      idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
